data_mem_responder: RTL and testbench

- Memory-stage responder for the pipelined CPU: services the load/store request the datapath presents in M (address = ALUOutM, data = WriteDataM) and returns ReadDataM.
- Models a word-addressed data RAM with a configurable number of wait states.
- Raises MemStallM to the hazard unit while an access is in flight; the hazard unit freezes F/D/E/M and bubbles W.
- Flags misaligned and out-of-range accesses.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_ram.sv | 24 ++
 rtl/data_mem_responder.sv | 142 ++++++++++++++
 tb/tb_data_mem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the memory-stage data responder.
// Provides the FSM state enum, counter width and default MMIO address.
package dmem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int CNT_W = 4;

    localparam logic [31:0] MMIO_ADDR_DEF = 32'hFFFF_FF00;

endpackage

// File: rtl/dmem_ram.sv
// Word-wide data RAM: synchronous write, asynchronous read, no reset.
// Ports: clk, we (write enable), addr (word index), wdata, rdata.
module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// M-stage load/store responder: word RAM with WAIT_STATES stall cycles,
// misalignment/range error flags and an optional I/O register.
// Ports: clk, reset (async, active high); MemReqM, MemWriteM, ALUOutM,
//   WriteDataM in; ReadDataM, MemStallM, MemErrM, ErrStickyM out;
//   IoOutM out, IoInM in (I/O register, used only when DMEM_MMIO_EN
//   is defined; otherwise IoOutM is 0 and MMIO_ADDR is an error).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] MMIO_ADDR   = MMIO_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        MemStallM,
    output logic        MemErrM,
    output logic        ErrStickyM,
    output logic [31:0] IoOutM,
    input  logic [31:0] IoInM
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_data;
    logic             lat_write;

    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        done;
    logic        live;
    logic        mmio_hit;
    logic        illegal;
    logic        ram_we;
    logic [31:0] ram_rdata;

    // With zero wait states the request completes in its first cycle,
    // so the live inputs are used instead of the latched copy.
    assign addr  = (state == WAIT) ? lat_addr  : ALUOutM;
    assign wdata = (state == WAIT) ? lat_data  : WriteDataM;
    assign write = (state == WAIT) ? lat_write : MemWriteM;

    assign done = (state == WAIT) ? (cnt == '0)
                                  : (MemReqM && WAIT_STATES == 0);

    // Reset masks the completion so a pending store is dropped.
    assign live = done && !reset;

`ifdef DMEM_MMIO_EN
    assign mmio_hit = (addr == MMIO_ADDR);
`else
    assign mmio_hit = 1'b0;
`endif

    // 33-bit compare so the limit check cannot wrap.
    assign illegal = (addr[1:0] != 2'b00)
                  || (({1'b0, addr} >= LIMIT) && !mmio_hit);

    assign ram_we = live && write && !illegal && !mmio_hit;

    assign MemStallM = !reset && (
        (state == IDLE && MemReqM && WAIT_STATES != 0) ||
        (state == WAIT && cnt != '0));

    assign MemErrM = live && illegal;

    assign ReadDataM = (live && !write && !illegal)
                     ? (mmio_hit ? IoInM : ram_rdata)
                     : 32'h0;

    dmem_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr[AW+1:2]),
        .wdata (wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_write <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (MemReqM && WAIT_STATES != 0) begin
                        state     <= WAIT;
                        cnt       <= CNT_W'(WAIT_STATES - 1);
                        lat_addr  <= ALUOutM;
                        lat_data  <= WriteDataM;
                        lat_write <= MemWriteM;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ErrStickyM <= 1'b0;
        end else if (MemErrM) begin
            ErrStickyM <= 1'b1;
        end
    end

`ifdef DMEM_MMIO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            IoOutM <= '0;
        end else if (live && write && mmio_hit) begin
            IoOutM <= wdata;
        end
    end
`else
    assign IoOutM = '0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a scoreboard queue.
// Instance a uses 2 wait states, instance b uses 0 wait states.
module tb_data_mem_responder;

`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    localparam logic [31:0] MMIO = 32'hFFFF_FF00;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wd;
    logic [1:0][31:0] rd;
    logic [1:0]       stall;
    logic [1:0]       err;
    logic [1:0]       sticky;
    logic [1:0][31:0] io_out;
    logic [1:0][31:0] io_in;

    exp_t        q[$];
    logic [31:0] mdl [bit [32:0]];
    logic [31:0] io_exp [2];
    int          n_chk;
    int          n_fail;

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (2)
    ) u_a (
        .clk        (clk),
        .reset      (reset),
        .MemReqM    (req[0]),
        .MemWriteM  (we[0]),
        .ALUOutM    (addr[0]),
        .WriteDataM (wd[0]),
        .ReadDataM  (rd[0]),
        .MemStallM  (stall[0]),
        .MemErrM    (err[0]),
        .ErrStickyM (sticky[0]),
        .IoOutM     (io_out[0]),
        .IoInM      (io_in[0])
    );

    data_mem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (0)
    ) u_b (
        .clk        (clk),
        .reset      (reset),
        .MemReqM    (req[1]),
        .MemWriteM  (we[1]),
        .ALUOutM    (addr[1]),
        .WriteDataM (wd[1]),
        .ReadDataM  (rd[1]),
        .MemStallM  (stall[1]),
        .MemErrM    (err[1]),
        .ErrStickyM (sticky[1]),
        .IoOutM     (io_out[1]),
        .IoInM      (io_in[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // One access on instance s. Model and expected result are updated
    // when the request is driven; the result is checked on completion.
    task automatic acc(input int s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input bit perturb);
        exp_t      e;
        exp_t      got;
        int        n;
        bit        mm;
        bit        ill;
        bit [32:0] key;
        key   = {s[0], a};
        mm    = MMIO_EN && (a == MMIO);
        ill   = (a[1:0] != 2'b00) || ((a >= 32'd4096) && !mm);
        e.err = ill;
        e.rd  = 32'h0;
        if (!ill && !w) e.rd = mm ? io_in[s] : mdl[key];
        if (!ill && w) begin
            if (mm) io_exp[s] = d;
            else    mdl[key] = d;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        req[s]  = 1'b1;
        we[s]   = w;
        addr[s] = a;
        wd[s]   = d;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall[s]) break;
            n++;
            if (n > 40) break;
            if (perturb && n == 1) begin
                @(posedge clk);
                #1;
                req[s]  = 1'b0;
                addr[s] = a + 32'd4;
                wd[s]   = ~d;
                we[s]   = ~w;
            end
        end
        got = q.pop_front();
        if (n > 40) begin
            chk("timeout", 32'd1, 32'd0);
        end else begin
            chk($sformatf("stalls_%0d_%h", s, a), n, (s == 0) ? 2 : 0);
            chk($sformatf("rdata_%0d_%h", s, a), rd[s], got.rd);
            chk($sformatf("err_%0d_%h", s, a), {31'b0, err[s]},
                {31'b0, got.err});
        end
    endtask

    task automatic idle(input int s);
        @(posedge clk);
        #1;
        req[s] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        req    = '0;
        we     = '0;
        addr   = '0;
        wd     = '0;
        io_in  = '0;
        io_exp[0] = 32'h0;
        io_exp[1] = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'b0, stall[0]}, 32'd0);
        chk("rst_err", {31'b0, err[0]}, 32'd0);
        chk("rst_sticky", {31'b0, sticky[0]}, 32'd0);
        chk("rst_rdata", rd[0], 32'h0);
        chk("rst_io", io_out[0], 32'h0);
        reset = 1'b0;

        acc(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        acc(0, 1'b0, 32'h10, 32'h0, 1'b0);
        idle(0);
        chk("idle_rdata", rd[0], 32'h0);

        acc(0, 1'b1, 32'h12, 32'hAAAA5555, 1'b0);
        chk("sticky_pre", {31'b0, sticky[0]}, 32'd0);
        idle(0);
        chk("err_one_pulse", {31'b0, err[0]}, 32'd0);
        chk("sticky_set", {31'b0, sticky[0]}, 32'd1);
        acc(0, 1'b0, 32'h10, 32'h0, 1'b0);

        acc(0, 1'b0, 32'h1000, 32'h0, 1'b0);
        acc(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);
        acc(0, 1'b0, 32'hFFC, 32'h0, 1'b0);

        io_in[0] = 32'h1234;
        acc(0, 1'b1, MMIO, 32'h5A, 1'b0);
        idle(0);
        chk("io_out", io_out[0], io_exp[0]);
        acc(0, 1'b0, MMIO, 32'h0, 1'b0);

        acc(0, 1'b1, 32'h24, 32'h0BADF00D, 1'b0);
        acc(0, 1'b1, 32'h20, 32'hCAFE0000, 1'b1);
        idle(0);
        acc(0, 1'b0, 32'h20, 32'h0, 1'b0);
        acc(0, 1'b0, 32'h24, 32'h0, 1'b0);
        idle(0);
        chk("sticky_hold", {31'b0, sticky[0]}, 32'd1);

        @(posedge clk);
        #1;
        req[0]  = 1'b1;
        we[0]   = 1'b1;
        addr[0] = 32'h20;
        wd[0]   = 32'h11111111;
        @(negedge clk);
        chk("wait_stall_0", {31'b0, stall[0]}, 32'd1);
        @(negedge clk);
        chk("wait_stall_1", {31'b0, stall[0]}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_stall", {31'b0, stall[0]}, 32'd0);
        chk("rst_async_sticky", {31'b0, sticky[0]}, 32'd0);
        chk("rst_async_io", io_out[0], 32'h0);
        req[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        acc(0, 1'b0, 32'h20, 32'h0, 1'b0);
        idle(0);
        chk("sticky_after_rst", {31'b0, sticky[0]}, 32'd0);

        acc(1, 1'b1, 32'h0, 32'h01020304, 1'b0);
        acc(1, 1'b1, 32'h4, 32'hA5A5A5A5, 1'b0);
        acc(1, 1'b0, 32'h0, 32'h0, 1'b0);
        acc(1, 1'b0, 32'h4, 32'h0, 1'b0);
        acc(1, 1'b0, 32'h6, 32'h0, 1'b0);
        idle(1);
        chk("b_sticky", {31'b0, sticky[1]}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
